// File: rtl/raster_pixel_source.sv
// Raster-ordered pixel stream source: emits one WIDTH x HEIGHT frame per
// accepted start, with selectable test patterns, optional horizontal
// blanking and a valid/ready handshake toward the line buffer.
module raster_pixel_source #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PIXEL_WIDTH = 8,
    parameter int COL_WIDTH   = 10,
    parameter int ROW_WIDTH   = 9,
    parameter int HBLANK      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             pattern,
    input  logic                   ready,
    output logic                   valid,
    output logic [COL_WIDTH-1:0]   col,
    output logic [ROW_WIDTH-1:0]   row,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   line_flag,
    output logic                   frame_done,
    output logic                   busy
);

    // Blank counter only ever holds HBLANK-1 down to 0.
    localparam int BLANK_WIDTH = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_BLANK
    } state_t;

    state_t                 state_q, state_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [PIXEL_WIDTH-1:0] beat_q, beat_d;
    logic [1:0]             pat_q, pat_d;
    logic [BLANK_WIDTH-1:0] blank_q, blank_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
    logic                   line_flag_q, line_flag_d;

    function automatic logic [PIXEL_WIDTH-1:0] pattern_pixel(
        input logic [1:0]             p,
        input logic [COL_WIDTH-1:0]   c,
        input logic [ROW_WIDTH-1:0]   r,
        input logic [PIXEL_WIDTH-1:0] n
    );
        case (p)
            2'd0:    return n;
            2'd1:    return PIXEL_WIDTH'(c);
            2'd2:    return PIXEL_WIDTH'(r);
            default: return PIXEL_WIDTH'(c) ^ PIXEL_WIDTH'(r);
        endcase
    endfunction

    // Next-state, coordinate advance and registered-output precomputation.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        beat_d       = beat_q;
        pat_d        = pat_q;
        blank_d      = blank_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                // A start coinciding with the frame_done pulse is dropped.
                if (start && !frame_done_q) begin
                    state_d = ST_ACTIVE;
                    pat_d   = pattern;
                    col_d   = '0;
                    row_d   = '0;
                    beat_d  = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (valid_q && ready) begin
                    beat_d = beat_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d      = ST_IDLE;
                            valid_d      = 1'b0;
                            frame_done_d = 1'b1;
                        end else begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                            if (HBLANK > 0) begin
                                state_d = ST_BLANK;
                                valid_d = 1'b0;
                                blank_d = BLANK_WIDTH'(HBLANK - 1);
                            end
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_q == '0) begin
                    state_d = ST_ACTIVE;
                    valid_d = 1'b1;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Pixel and line marker are computed from the next coordinates so the
        // outputs are registered yet aligned with the beat they describe.
        pixel_d     = valid_d ? pattern_pixel(pat_d, col_d, row_d, beat_d) : '0;
        line_flag_d = valid_d && (col_d == COL_LAST);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            beat_q       <= '0;
            pat_q        <= '0;
            blank_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pixel_q      <= '0;
            line_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            beat_q       <= beat_d;
            pat_q        <= pat_d;
            blank_q      <= blank_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pixel_q      <= pixel_d;
            line_flag_q  <= line_flag_d;
        end
    end

    assign valid      = valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign pixel_out  = pixel_q;
    assign line_flag  = line_flag_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_raster_pixel_source.sv
// Bench for raster_pixel_source: two small configurations (no blanking and
// with blanking) driven frame by frame and compared with a raster model.
module tb_raster_pixel_source;

    localparam int W0 = 8, H0 = 6, PW0 = 4, HB0 = 0;
    localparam int W1 = 4, H1 = 3, PW1 = 8, HB1 = 4;

    logic clk, rst;
    logic [1:0] pattern;
    logic start0, ready0, start1, ready1;

    logic       valid0, lf0, fd0, busy0;
    logic [2:0] col0;
    logic [2:0] row0;
    logic [3:0] pix0;

    logic       valid1, lf1, fd1, busy1;
    logic [1:0] col1;
    logic [1:0] row1;
    logic [7:0] pix1;

    raster_pixel_source #(
        .WIDTH(W0), .HEIGHT(H0), .PIXEL_WIDTH(PW0),
        .COL_WIDTH(3), .ROW_WIDTH(3), .HBLANK(HB0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern), .ready(ready0),
        .valid(valid0), .col(col0), .row(row0), .pixel_out(pix0),
        .line_flag(lf0), .frame_done(fd0), .busy(busy0)
    );

    raster_pixel_source #(
        .WIDTH(W1), .HEIGHT(H1), .PIXEL_WIDTH(PW1),
        .COL_WIDTH(2), .ROW_WIDTH(2), .HBLANK(HB1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pattern(pattern), .ready(ready1),
        .valid(valid1), .col(col1), .row(row1), .pixel_out(pix1),
        .line_flag(lf1), .frame_done(fd1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selected DUT's outputs, widened for comparison.
    bit sel;
    logic        o_valid, o_lf, o_fd, o_busy;
    logic [31:0] o_col, o_row, o_pix;
    always_comb begin
        if (sel) begin
            o_valid = valid1; o_lf = lf1; o_fd = fd1; o_busy = busy1;
            o_col = 32'(col1); o_row = 32'(row1); o_pix = 32'(pix1);
        end else begin
            o_valid = valid0; o_lf = lf0; o_fd = fd0; o_busy = busy0;
            o_col = 32'(col0); o_row = 32'(row0); o_pix = 32'(pix0);
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start1 = v; else start0 = v;
    endtask

    task automatic set_ready(input bit s, input logic v);
        if (s) ready1 = v; else ready0 = v;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_col"}, o_col, 0);
        check({tag, "_row"}, o_row, 0);
        check({tag, "_pix"}, o_pix, 0);
        check({tag, "_lf"}, o_lf, 0);
        check({tag, "_fd"}, o_fd, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    typedef struct {
        int c;
        int r;
        int pix;
        int lf;
    } beat_t;

    // Runs one frame on DUT s; caller must be positioned at a falling edge.
    // mode: 0 ready always high, 1 random ready, 2 three-cycle stall at beat 5.
    task automatic run_frame(input bit s, input int pat, input int mode, input bit poke,
                             input int abort_row, input bit late_start);
        int w, h, hb, pw, n, idx, gap, cyc, first_cyc, last_cyc, lf_cnt, stalls;
        bit prev_stall, poked, aborted;
        logic rdy;
        logic [31:0] pc, pr, pp;
        logic plf;
        beat_t exp_q[$];
        beat_t b;

        w  = s ? W1 : W0;
        h  = s ? H1 : H0;
        hb = s ? HB1 : HB0;
        pw = s ? PW1 : PW0;

        // Reference raster: row-major order, beat index n counted from 0.
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (pat)
                    0:       b.pix = n % (1 << pw);
                    1:       b.pix = c % (1 << pw);
                    2:       b.pix = r % (1 << pw);
                    default: b.pix = (c ^ r) % (1 << pw);
                endcase
                b.c = c;
                b.r = r;
                b.lf = (c == w - 1) ? 1 : 0;
                exp_q.push_back(b);
                n++;
            end
        end

        sel = s;
        pattern = 2'(pat);
        set_ready(s, 1'b1);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        check("start_valid", o_valid, 1);
        check("start_busy", o_busy, 1);
        check("start_col", o_col, 0);
        check("start_row", o_row, 0);

        idx = 0; gap = -1; cyc = 0; first_cyc = 0; last_cyc = 0; lf_cnt = 0;
        stalls = 0; prev_stall = 0; poked = 0; aborted = 0;
        pc = 0; pr = 0; pp = 0; plf = 0;

        while (idx < w * h) begin
            set_start(s, 1'b0);
            if (cyc > 4000) begin
                check("timeout_beats", idx, w * h);
                break;
            end
            if (abort_row >= 0 && o_valid && o_row == 32'(abort_row)) begin
                aborted = 1;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (idx == 5 && stalls < 3) begin
                        rdy = 1'b0;
                        stalls++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            set_ready(s, rdy);

            if (prev_stall) begin
                check("hold_valid", o_valid, 1);
                check("hold_col", o_col, pc);
                check("hold_row", o_row, pr);
                check("hold_pix", o_pix, pp);
                check("hold_lf", o_lf, plf);
            end

            if (o_valid) begin
                if (gap >= 0) begin
                    check("hblank_gap", gap, hb);
                    gap = -1;
                end
                check("col", o_col, exp_q[idx].c);
                check("row", o_row, exp_q[idx].r);
                check("pix", o_pix, exp_q[idx].pix);
                check("line_flag", o_lf, exp_q[idx].lf);
                check("busy_active", o_busy, 1);
                check("fd_active", o_fd, 0);
                prev_stall = !rdy;
                pc = o_col; pr = o_row; pp = o_pix; plf = o_lf;
                if (rdy) begin
                    if (idx == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (o_lf) lf_cnt++;
                    if (o_lf && idx != w * h - 1) gap = 0;
                    idx++;
                end
            end else begin
                prev_stall = 0;
                check("gap_only_in_blank", (gap >= 0) ? 1 : 0, 1);
                if (gap >= 0) gap++;
                check("busy_blank", o_busy, 1);
                check("fd_blank", o_fd, 0);
            end

            if (poke && !poked && idx == 10) begin
                set_start(s, 1'b1);
                pattern = 2'((pat + 1) % 4);
                poked = 1;
            end
            @(negedge clk);
            cyc++;
        end
        set_start(s, 1'b0);

        if (aborted) begin
            #2 rst = 1'b1;
            #1 check_outputs_zero("abort");
            @(negedge clk);
            rst = 1'b0;
            set_ready(s, 1'b1);
            repeat (6) begin
                @(negedge clk);
                check("abort_no_fd", o_fd, 0);
                check("abort_idle", o_valid, 0);
            end
            return;
        end

        // Now one falling edge after the final beat was accepted.
        check("done_fd", o_fd, 1);
        check("done_valid", o_valid, 0);
        check("done_busy", o_busy, 1);
        check("line_flag_count", lf_cnt, h);
        if (mode == 0) check("frame_span", last_cyc - first_cyc + 1, w * h + (h - 1) * hb);
        if (late_start) set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        check("post_fd", o_fd, 0);
        check("post_busy", o_busy, 0);
        check("post_valid", o_valid, 0);
        @(negedge clk);
        check("post_valid2", o_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        ready0 = 1'b0; ready1 = 1'b0;
        pattern = 2'd0;
        sel = 0;
        @(negedge clk);
        check_outputs_zero("reset0");
        sel = 1;
        #0 check_outputs_zero("reset1");
        sel = 0;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_valid0", valid0, 0);
            check("idle_valid1", valid1, 0);
        end

        run_frame(0, 0, 0, 0, -1, 1);  // counter pattern, full rate, start on frame_done
        run_frame(0, 0, 2, 0, -1, 0);  // three-cycle stall at col 5
        run_frame(0, 3, 1, 1, -1, 0);  // xor pattern, random ready, start mid-frame
        run_frame(0, 1, 1, 0, -1, 0);
        run_frame(0, 2, 1, 0, -1, 0);
        run_frame(1, 0, 0, 0, -1, 0);  // blanking, full rate span
        run_frame(1, 3, 1, 1, -1, 1);
        run_frame(1, 1, 1, 0, 1, 0);   // abort during blanking config
        run_frame(0, 0, 1, 0, 2, 0);   // abort at row 2
        run_frame(0, 0, 0, 0, -1, 0);  // restart after abort
        run_frame(1, 2, 0, 0, -1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/raster_pixel_source.md
# raster_pixel_source

Frame-rate pixel stream generator that drives the write side of the line-buffer stage. It produces the raster-ordered `col`/`row` coordinates, pixel data and line/frame markers that line-buffered filters consume. Downstream back-pressure is handled with a valid/ready handshake. It is the standard stimulus and bring-up source ahead of the line buffer and window stages: selectable test patterns, optional horizontal blanking, one frame per `start` pulse.

## Interface
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, lines per frame
- `PIXEL_WIDTH`, 8, pixel data width
- `COL_WIDTH`, 10, column index width (2^COL_WIDTH ≥ WIDTH)
- `ROW_WIDTH`, 9, row index width (2^ROW_WIDTH ≥ HEIGHT)
- `HBLANK`, 0, idle cycles inserted after each line except the last; 0 means none

- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to emit one frame; ignored while `busy`
- `pattern`  in  2  pattern select, sampled only on an accepted `start`
- `ready`  in  1  downstream can accept the current beat
- `valid`  out  1  `col`/`row`/`pixel_out`/`line_flag` carry a beat
- `col`  out  COL_WIDTH  column of current beat
- `row`  out  ROW_WIDTH  row of current beat
- `pixel_out`  out  PIXEL_WIDTH  pixel data of current beat
- `line_flag`  out  1  high on the beat with `col == WIDTH-1`
- `frame_done`  out  1  one-cycle pulse after the final beat of a frame is accepted
- `busy`  out  1  high from the accepted `start` until `frame_done`, inclusive

## Operation
- **FSM states:** IDLE, ACTIVE, BLANK.
  - IDLE → ACTIVE on `start`. Latch `pattern`. Clear `col`, `row` and the beat counter.
  - ACTIVE: a beat is transferred when `valid & ready`.
  - On a transfer with `col == WIDTH-1`:
    - `row < HEIGHT-1`: `col ← 0`, `row ← row+1`. Go to BLANK if `HBLANK > 0`, otherwise stay in ACTIVE.
    - `row == HEIGHT-1`: go to IDLE and pulse `frame_done` on the next cycle.
  - On any other transfer: `col ← col+1`.
  - BLANK: `valid = 0` for exactly `HBLANK` cycles (down-counter), then return to ACTIVE.
- **Pattern values** (`pattern` latched as `p`; `n` = beats accepted so far this frame):
  - `p = 0`: `pixel_out = n mod 2^PIXEL_WIDTH`. `n` is reset to 0 at each `start`.
  - `p = 1`: `pixel_out = col` zero-extended or truncated to `PIXEL_WIDTH`.
  - `p = 2`: `pixel_out = row` zero-extended or truncated to `PIXEL_WIDTH`.
  - `p = 3`: `pixel_out = (col ^ row)`, low `PIXEL_WIDTH` bits.
- **Back-pressure:** while `valid & !ready`, every output stays stable. No beat is dropped or repeated.
- **Arithmetic:** all counters wrap modulo their declared width. `col` never exceeds `WIDTH-1` and `row` never exceeds `HEIGHT-1`.
- **Start handling:** `start` is ignored in ACTIVE and BLANK. `start` in the same cycle as `frame_done` is ignored; the block accepts `start` from the following cycle.
- **Reset mid-frame:** `rst` aborts the frame immediately with no `frame_done`.

## Timing
- **Reset values:** `valid = 0`, `col = 0`, `row = 0`, `pixel_out = 0`, `line_flag = 0`, `frame_done = 0`, `busy = 0`. FSM returns to IDLE.
- **Start latency:** `start` sampled at edge k gives `valid = 1`, `col = 0`, `row = 0` and `busy = 1` after edge k.
- **Throughput:** with `ready` held high and `HBLANK = 0`, one beat per cycle with no gaps, including across line boundaries.
- **Frame length:** `WIDTH*HEIGHT + (HEIGHT-1)*HBLANK` cycles from the first beat to the last, when `ready` is held high.
- **Frame end:** `frame_done = 1` for one cycle immediately after the edge that accepts the final beat. `valid = 0` in that same cycle.
- **Register-driven outputs:** all outputs are registered. `ready` has no combinational path to any output.

## Test plan
- **Reset:** assert `rst` asynchronously, mid-cycle, during ACTIVE → all outputs go to reset values before the next edge. With no `start`, `valid` stays 0.
- **Full frame, counter pattern:** defaults, `pattern = 0`, `ready = 1` → 307200 consecutive beats with `pixel_out = n mod 256`. `line_flag` is high exactly 480 times. Final beat is `col = 639`, `row = 479`, `pixel_out = 255`. `frame_done` follows one cycle later.
- **Back-pressure:** `ready = 0` for 3 cycles while `col = 5`, `row = 0` → `col = 5`, `pixel_out = 5` held for all 3 cycles. The next accepted beat is `col = 6`, with no skipped or duplicated beat.
- **Blanking:** `WIDTH = 4`, `HEIGHT = 3`, `HBLANK = 4`, `ready = 1` → `valid` is low for exactly 4 cycles after each of the first two lines. Total first-to-last-beat span is 20 cycles.
- **XOR pattern:** `WIDTH = 8`, `HEIGHT = 8`, `pattern = 3` → beat at `col = 3`, `row = 5` has `pixel_out = 6`. `start` pulsed during the frame, and with `pattern` changed to 1, has no effect on anything.
- **Reset abort and restart:** `rst` at `row = 2`, then `start` → the new frame begins at `col = 0`, `row = 0` with `n` restarted at 0. No `frame_done` is produced for the aborted frame.
